// File: rtl/mem_stage_access_ctrl.sv
// MEM stage of the SIMD AES core: scalar load/store and 4-beat vector
// loads over a req/ack data port, with EX/MEM stall and registered MEM/WB.
module mem_stage_access_ctrl #(
   parameter int ADDR_STRIDE = 4,
   parameter int TIMEOUT     = 255
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   input  logic [31:0]  mem_alu_result,
   input  logic [31:0]  mem_write_data,
   input  logic [4:0]   mem_rd,
   input  logic         mem_reg_write,
   input  logic         mem_vreg_write,
   input  logic         mem_mem_write,
   input  logic [1:0]   mem_mem_to_reg,
   input  logic         mem_colwrite,
   input  logic [1:0]   mem_columna,
   output logic         stall,
   output logic         dmem_req,
   output logic         dmem_we,
   output logic [31:0]  dmem_addr,
   output logic [31:0]  dmem_wdata,
   input  logic [31:0]  dmem_rdata,
   input  logic         dmem_ack,
   output logic         wb_valid,
   output logic [4:0]   wb_rd,
   output logic [31:0]  wb_data,
   output logic [127:0] wb_vdata,
   output logic         wb_reg_write,
   output logic         wb_vreg_write,
   output logic         wb_colwrite,
   output logic [1:0]   wb_columna,
   output logic         err
);

   typedef enum logic [1:0] {IDLE, SREQ, VREQ, DONE} state_e;

   localparam logic [31:0] STRIDE   = 32'(ADDR_STRIDE);
   localparam logic [7:0]  TMO_LAST = 8'(TIMEOUT - 1);

   state_e       state_q;
   logic [1:0]   beat_q;
   logic [7:0]   tmo_q;
   logic         err_q;

   logic [31:0]  addr_q;
   logic [31:0]  wdata_q;
   logic         we_q;
   logic [4:0]   rd_q;
   logic         rw_q;
   logic         vw_q;
   logic         cw_q;
   logic [1:0]   col_q;
   logic [95:0]  vbuf_q;

   logic         wb_valid_q;
   logic [4:0]   wb_rd_q;
   logic [31:0]  wb_data_q;
   logic [127:0] wb_vdata_q;
   logic         wb_rw_q;
   logic         wb_vw_q;
   logic         wb_cw_q;
   logic [1:0]   wb_col_q;

   logic         needs_mem;
   logic         busy;
   logic [31:0]  beat_addr;

   assign needs_mem = mem_mem_write
                    | (mem_mem_to_reg == 2'b01)
                    | (mem_mem_to_reg == 2'b10);

   assign busy      = (state_q == SREQ) | (state_q == VREQ);
   assign beat_addr = addr_q + ({30'd0, beat_q} * STRIDE);

   assign stall = busy
                | ((state_q == IDLE) & in_valid & needs_mem);

   assign dmem_req   = busy;
   assign dmem_we    = (state_q == SREQ) & we_q;
   assign dmem_addr  = (state_q == SREQ) ? addr_q :
                       (state_q == VREQ) ? beat_addr : 32'd0;
   assign dmem_wdata = (state_q == SREQ) ? wdata_q : 32'd0;

   assign wb_valid      = wb_valid_q;
   assign wb_rd         = wb_rd_q;
   assign wb_data       = wb_data_q;
   assign wb_vdata      = wb_vdata_q;
   assign wb_reg_write  = wb_rw_q;
   assign wb_vreg_write = wb_vw_q;
   assign wb_colwrite   = wb_cw_q;
   assign wb_columna    = wb_col_q;
   assign err           = err_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         beat_q     <= '0;
         tmo_q      <= '0;
         err_q      <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         we_q       <= 1'b0;
         rd_q       <= '0;
         rw_q       <= 1'b0;
         vw_q       <= 1'b0;
         cw_q       <= 1'b0;
         col_q      <= '0;
         vbuf_q     <= '0;
         wb_valid_q <= 1'b0;
         wb_rd_q    <= '0;
         wb_data_q  <= '0;
         wb_vdata_q <= '0;
         wb_rw_q    <= 1'b0;
         wb_vw_q    <= 1'b0;
         wb_cw_q    <= 1'b0;
         wb_col_q   <= '0;
      end else begin
         wb_valid_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               beat_q <= '0;
               tmo_q  <= '0;
               if (in_valid && needs_mem) begin
                  addr_q  <= mem_alu_result;
                  wdata_q <= mem_write_data;
                  we_q    <= mem_mem_write;
                  rd_q    <= mem_rd;
                  rw_q    <= mem_reg_write;
                  vw_q    <= mem_vreg_write;
                  cw_q    <= mem_colwrite;
                  col_q   <= mem_columna;
                  vbuf_q  <= '0;
                  // a store wins over a vector load encoding
                  state_q <= (mem_mem_write ||
                              mem_mem_to_reg == 2'b01) ? SREQ : VREQ;
               end else if (in_valid) begin
                  wb_valid_q <= 1'b1;
                  wb_rd_q    <= mem_rd;
                  wb_data_q  <= mem_alu_result;
                  wb_vdata_q <= '0;
                  wb_rw_q    <= mem_reg_write;
                  wb_vw_q    <= mem_vreg_write;
                  wb_cw_q    <= mem_colwrite;
                  wb_col_q   <= mem_columna;
               end
            end
            SREQ, VREQ: begin
               if (dmem_ack) begin
                  tmo_q <= '0;
                  if (state_q == SREQ) begin
                     wb_valid_q <= 1'b1;
                     wb_rd_q    <= rd_q;
                     wb_data_q  <= we_q ? 32'd0 : dmem_rdata;
                     wb_vdata_q <= '0;
                     wb_rw_q    <= rw_q & ~we_q;
                     wb_vw_q    <= vw_q & ~we_q;
                     wb_cw_q    <= cw_q;
                     wb_col_q   <= col_q;
                     state_q    <= DONE;
                  end else if (beat_q == 2'd3) begin
                     wb_valid_q <= 1'b1;
                     wb_rd_q    <= rd_q;
                     wb_data_q  <= '0;
                     wb_vdata_q <= {dmem_rdata, vbuf_q};
                     wb_rw_q    <= rw_q;
                     wb_vw_q    <= vw_q;
                     wb_cw_q    <= cw_q;
                     wb_col_q   <= col_q;
                     state_q    <= DONE;
                  end else begin
                     unique case (beat_q)
                        2'd0:    vbuf_q[31:0]  <= dmem_rdata;
                        2'd1:    vbuf_q[63:32] <= dmem_rdata;
                        default: vbuf_q[95:64] <= dmem_rdata;
                     endcase
                     beat_q <= beat_q + 2'd1;
                  end
               end else if (tmo_q == TMO_LAST) begin
                  // abort: result slot is emitted but writes nothing
                  err_q      <= 1'b1;
                  wb_valid_q <= 1'b1;
                  wb_rd_q    <= rd_q;
                  wb_rw_q    <= 1'b0;
                  wb_vw_q    <= 1'b0;
                  wb_cw_q    <= 1'b0;
                  wb_col_q   <= col_q;
                  state_q    <= DONE;
               end else begin
                  tmo_q <= tmo_q + 8'd1;
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_stage_access_ctrl.sv
// Bench for mem_stage_access_ctrl: scripted EX/MEM stimulus, a responding
// data memory and a scoreboard of expected MEM/WB results.
module tb_mem_stage_access_ctrl;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic [31:0]  mem_alu_result;
   logic [31:0]  mem_write_data;
   logic [4:0]   mem_rd;
   logic         mem_reg_write;
   logic         mem_vreg_write;
   logic         mem_mem_write;
   logic [1:0]   mem_mem_to_reg;
   logic         mem_colwrite;
   logic [1:0]   mem_columna;
   logic         stall;
   logic         dmem_req;
   logic         dmem_we;
   logic [31:0]  dmem_addr;
   logic [31:0]  dmem_wdata;
   logic [31:0]  dmem_rdata;
   logic         dmem_ack;
   logic         wb_valid;
   logic [4:0]   wb_rd;
   logic [31:0]  wb_data;
   logic [127:0] wb_vdata;
   logic         wb_reg_write;
   logic         wb_vreg_write;
   logic         wb_colwrite;
   logic [1:0]   wb_columna;
   logic         err;

   mem_stage_access_ctrl dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .in_valid       (in_valid),
      .mem_alu_result (mem_alu_result),
      .mem_write_data (mem_write_data),
      .mem_rd         (mem_rd),
      .mem_reg_write  (mem_reg_write),
      .mem_vreg_write (mem_vreg_write),
      .mem_mem_write  (mem_mem_write),
      .mem_mem_to_reg (mem_mem_to_reg),
      .mem_colwrite   (mem_colwrite),
      .mem_columna    (mem_columna),
      .stall          (stall),
      .dmem_req       (dmem_req),
      .dmem_we        (dmem_we),
      .dmem_addr      (dmem_addr),
      .dmem_wdata     (dmem_wdata),
      .dmem_rdata     (dmem_rdata),
      .dmem_ack       (dmem_ack),
      .wb_valid       (wb_valid),
      .wb_rd          (wb_rd),
      .wb_data        (wb_data),
      .wb_vdata       (wb_vdata),
      .wb_reg_write   (wb_reg_write),
      .wb_vreg_write  (wb_vreg_write),
      .wb_colwrite    (wb_colwrite),
      .wb_columna     (wb_columna),
      .err            (err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [4:0]   rd;
      logic [31:0]  data;
      logic [127:0] vdata;
      logic         rw;
      logic         vw;
      logic         cw;
      logic [1:0]   col;
   } exp_t;

   exp_t exp_q[$];
   exp_t wb_obs;
   assign wb_obs = {wb_rd, wb_data, wb_vdata, wb_reg_write,
                    wb_vreg_write, wb_colwrite, wb_columna};

   int checks = 0;
   int errors = 0;

   logic [31:0] rdata_tab[4];
   logic [31:0] addr_seen[4];
   logic [31:0] wdata_seen;
   logic        we_seen;
   int          n_acks, n_stall, n_req;
   bit          got_wb;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [1:0] m2r,
                        input logic [31:0] alu, input logic [31:0] wd,
                        input logic [4:0] rd, input logic rw,
                        input logic vw, input logic mw,
                        input logic cw, input logic [1:0] col);
      in_valid       = v;
      mem_mem_to_reg = m2r;
      mem_alu_result = alu;
      mem_write_data = wd;
      mem_rd         = rd;
      mem_reg_write  = rw;
      mem_vreg_write = vw;
      mem_mem_write  = mw;
      mem_colwrite   = cw;
      mem_columna    = col;
   endtask

   // Memory responder: acks on the lat-th cycle of each beat (lat=0: never).
   // Returns at the sample point of the cycle where wb_valid is seen.
   task automatic serve(input int lat, input int budget);
      int wcnt;
      wcnt = 0;
      n_acks = 0; n_stall = 0; n_req = 0;
      got_wb = 0; we_seen = 0;
      for (int cyc = 0; cyc < budget && !got_wb; cyc++) begin
         #1;
         if (stall) n_stall++;
         if (wb_valid) got_wb = 1;
         else begin
            if (dmem_req) begin
               n_req++;
               wcnt++;
               we_seen = we_seen | dmem_we;
               if (lat > 0 && wcnt == lat) begin
                  dmem_ack   = 1'b1;
                  dmem_rdata = rdata_tab[n_acks & 3];
                  addr_seen[n_acks & 3] = dmem_addr;
                  wdata_seen = dmem_wdata;
                  n_acks++;
                  wcnt = 0;
               end
            end
            tick;
            dmem_ack = 1'b0;
         end
      end
      dmem_ack = 1'b0;
   endtask

   task automatic test_reset;
      exp_t e;
      rst_n = 1'b0;
      drive(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
      dmem_ack = 1'b0;
      dmem_rdata = '0;
      repeat (3) tick;
      #1;
      checks++;
      if ({stall, dmem_req, dmem_we, dmem_addr, dmem_wdata} !== '0) begin
         errors++;
         $display("FAIL reset_dmem: got %h want 0",
                  {stall, dmem_req, dmem_we, dmem_addr, dmem_wdata});
      end
      e = '0;
      checks++;
      if ({wb_valid, err, wb_obs} !== {2'b00, e}) begin
         errors++;
         $display("FAIL reset_wb: got %h want 0", {wb_valid, err, wb_obs});
      end
      tick;
      rst_n = 1'b1;
   endtask

   task automatic test_alu;
      exp_t e;
      tick;
      drive(1, 2'b00, 32'h1234, 32'h9999, 5, 1, 0, 0, 1, 2);
      exp_q.push_back('{5'd5, 32'h1234, 128'd0, 1'b1, 1'b0, 1'b1, 2'd2});
      #1;
      checks++;
      if (stall !== 1'b0) begin
         errors++; $display("FAIL alu_stall: got %b want 0", stall);
      end
      tick;
      in_valid = 1'b0;
      #1;
      checks++;
      if (wb_valid !== 1'b1) begin
         errors++; $display("FAIL alu_valid: got %b want 1", wb_valid);
      end else if (exp_q.size() == 0) begin
         errors++; $display("FAIL alu_sb: got result want none queued");
      end else begin
         e = exp_q.pop_front();
         if (wb_obs !== e) begin
            errors++; $display("FAIL alu_sb: got %h want %h", wb_obs, e);
         end
      end
      tick;
      #1;
      checks++;
      if ({wb_valid, stall} !== 2'b00) begin
         errors++;
         $display("FAIL alu_pulse: got %b want 00", {wb_valid, stall});
      end
      exp_q.delete();
   endtask

   task automatic test_scalar_load;
      exp_t e;
      tick;
      drive(1, 2'b01, 32'h40, 32'h0, 7, 1, 0, 0, 0, 1);
      rdata_tab[0] = 32'hDEADBEEF;
      exp_q.push_back('{5'd7, 32'hDEADBEEF, 128'd0, 1'b1, 1'b0, 1'b0, 2'd1});
      serve(3, 50);
      checks++;
      if (!got_wb) begin
         errors++; $display("FAIL ld_timeout: got no wb_valid want 1");
      end else begin
         e = exp_q.pop_front();
         if (wb_obs !== e) begin
            errors++; $display("FAIL ld_sb: got %h want %h", wb_obs, e);
         end
      end
      checks++;
      if (n_stall !== 4 || n_req !== 3) begin
         errors++;
         $display("FAIL ld_cycles: got stall=%0d req=%0d want 4 3",
                  n_stall, n_req);
      end
      checks++;
      if (addr_seen[0] !== 32'h40 || we_seen !== 1'b0) begin
         errors++;
         $display("FAIL ld_addr: got %h we=%b want 00000040 0",
                  addr_seen[0], we_seen);
      end
      tick;
      in_valid = 1'b0;
      #1;
      checks++;
      if ({wb_valid, dmem_req, stall} !== 3'b000) begin
         errors++;
         $display("FAIL ld_done: got %b want 000",
                  {wb_valid, dmem_req, stall});
      end
      exp_q.delete();
   endtask

   task automatic test_store;
      exp_t e;
      tick;
      drive(1, 2'b00, 32'h10, 32'hCAFE, 3, 1, 1, 1, 0, 0);
      rdata_tab[0] = 32'h55AA55AA;
      exp_q.push_back('{5'd3, 32'h0, 128'd0, 1'b0, 1'b0, 1'b0, 2'd0});
      serve(1, 50);
      checks++;
      if (!got_wb) begin
         errors++; $display("FAIL st_timeout: got no wb_valid want 1");
      end else begin
         e = exp_q.pop_front();
         if (wb_obs !== e) begin
            errors++; $display("FAIL st_sb: got %h want %h", wb_obs, e);
         end
      end
      checks++;
      if (n_req !== 1 || we_seen !== 1'b1 || n_stall !== 2) begin
         errors++;
         $display("FAIL st_req: got req=%0d we=%b stall=%0d want 1 1 2",
                  n_req, we_seen, n_stall);
      end
      checks++;
      if (addr_seen[0] !== 32'h10 || wdata_seen !== 32'hCAFE) begin
         errors++;
         $display("FAIL st_bus: got %h %h want 00000010 0000cafe",
                  addr_seen[0], wdata_seen);
      end
      checks++;
      if ({dmem_we, dmem_req} !== 2'b00) begin
         errors++;
         $display("FAIL st_drop: got %b want 00", {dmem_we, dmem_req});
      end
      tick;
      in_valid = 1'b0;
      exp_q.delete();
   endtask

   task automatic test_back_to_back;
      exp_t        e;
      logic [31:0] alu_t[3];
      logic [1:0]  m2r_t[3];
      logic [4:0]  rd_t[3];
      alu_t = '{32'hA0000001, 32'h000000B2, 32'h000000C3};
      m2r_t = '{2'b00, 2'b11, 2'b00};
      rd_t  = '{5'd1, 5'd2, 5'd31};
      tick;
      drive(1, 2'b01, 32'h200, 32'h0, 8, 1, 0, 0, 0, 0);
      rdata_tab[0] = 32'h0BADF00D;
      exp_q.push_back('{5'd8, 32'h0BADF00D, 128'd0, 1'b1, 1'b0, 1'b0, 2'd0});
      serve(1, 20);
      checks++;
      if (!got_wb) begin
         errors++; $display("FAIL b2b_ld: got no wb_valid want 1");
      end else begin
         e = exp_q.pop_front();
         if (wb_obs !== e) begin
            errors++; $display("FAIL b2b_ld: got %h want %h", wb_obs, e);
         end
      end
      for (int i = 0; i <= 3; i++) begin
         tick;
         if (i < 3) begin
            drive(1, m2r_t[i], alu_t[i], 32'h0, rd_t[i],
                  i[0], ~i[0], 0, i[0], 2'(i));
            exp_q.push_back('{rd_t[i], alu_t[i], 128'd0,
                              i[0], ~i[0], i[0], 2'(i)});
         end else begin
            in_valid = 1'b0;
         end
         #1;
         checks++;
         if (stall !== 1'b0 || dmem_req !== 1'b0) begin
            errors++;
            $display("FAIL b2b_stall%0d: got %b want 00", i,
                     {stall, dmem_req});
         end
         checks++;
         if (i == 0) begin
            if (wb_valid !== 1'b0) begin
               errors++; $display("FAIL b2b_pulse: got 1 want 0");
            end
         end else if (wb_valid !== 1'b1 || exp_q.size() == 0) begin
            errors++;
            $display("FAIL b2b_valid%0d: got %b want 1", i, wb_valid);
         end else begin
            e = exp_q.pop_front();
            if (wb_obs !== e) begin
               errors++;
               $display("FAIL b2b_sb%0d: got %h want %h", i, wb_obs, e);
            end
         end
      end
      tick;
      #1;
      checks++;
      if (wb_valid !== 1'b0) begin
         errors++; $display("FAIL b2b_end: got 1 want 0");
      end
      exp_q.delete();
   endtask

   task automatic test_timeout;
      tick;
      drive(1, 2'b01, 32'h80, 32'h0, 9, 1, 1, 0, 1, 3);
      serve(0, 400);
      checks++;
      if (!got_wb) begin
         errors++; $display("FAIL tmo_wb: got no wb_valid want 1");
      end
      checks++;
      if (n_req !== 255 || n_stall !== 256) begin
         errors++;
         $display("FAIL tmo_cycles: got req=%0d stall=%0d want 255 256",
                  n_req, n_stall);
      end
      checks++;
      if ({err, dmem_req, stall} !== 3'b100) begin
         errors++;
         $display("FAIL tmo_flags: got %b want 100",
                  {err, dmem_req, stall});
      end
      checks++;
      if ({wb_reg_write, wb_vreg_write, wb_colwrite} !== 3'b000) begin
         errors++;
         $display("FAIL tmo_we: got %b want 000",
                  {wb_reg_write, wb_vreg_write, wb_colwrite});
      end
      tick;
      in_valid = 1'b0;
      #1;
      checks++;
      if ({wb_valid, err} !== 2'b01) begin
         errors++;
         $display("FAIL tmo_after: got %b want 01", {wb_valid, err});
      end
   endtask

   task automatic test_vector;
      exp_t e;
      tick;
      drive(1, 2'b10, 32'hFFFFFFF8, 32'h0, 4, 0, 1, 0, 0, 0);
      rdata_tab = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
      exp_q.push_back('{5'd4, 32'h0,
                        128'h44444444_33333333_22222222_11111111,
                        1'b0, 1'b1, 1'b0, 2'd0});
      serve(2, 60);
      checks++;
      if (!got_wb) begin
         errors++; $display("FAIL vec_wb: got no wb_valid want 1");
      end else begin
         e = exp_q.pop_front();
         if (wb_obs !== e) begin
            errors++; $display("FAIL vec_sb: got %h want %h", wb_obs, e);
         end
      end
      checks++;
      if ({addr_seen[0], addr_seen[1], addr_seen[2], addr_seen[3]} !==
          128'hFFFFFFF8_FFFFFFFC_00000000_00000004) begin
         errors++;
         $display("FAIL vec_addr: got %h %h %h %h want fffffff8 fffffffc 0 4",
                  addr_seen[0], addr_seen[1], addr_seen[2], addr_seen[3]);
      end
      checks++;
      if (n_req !== 8 || n_stall !== 9 || we_seen !== 1'b0) begin
         errors++;
         $display("FAIL vec_cycles: got req=%0d stall=%0d we=%b want 8 9 0",
                  n_req, n_stall, we_seen);
      end
      checks++;
      if (err !== 1'b1) begin
         errors++; $display("FAIL vec_err_sticky: got %b want 1", err);
      end
      tick;
      in_valid = 1'b0;
      exp_q.delete();
   endtask

   task automatic test_reset_mid;
      tick;
      drive(1, 2'b10, 32'h100, 32'h0, 6, 0, 1, 0, 0, 0);
      #1;
      for (int b = 0; b < 2; b++) begin
         tick;
         #1;
         dmem_rdata = 32'h77770000 + 32'(b);
         dmem_ack = 1'b1;
      end
      tick;
      dmem_ack = 1'b0;
      #1;
      checks++;
      if (dmem_req !== 1'b1 || dmem_addr !== 32'h108) begin
         errors++;
         $display("FAIL rst_beat2: got req=%b addr=%h want 1 00000108",
                  dmem_req, dmem_addr);
      end
      rst_n = 1'b0;
      in_valid = 1'b0;
      tick;
      #1;
      checks++;
      if ({dmem_req, stall, wb_valid, err} !== 4'b0000 ||
          wb_vdata !== 128'd0) begin
         errors++;
         $display("FAIL rst_mid: got %b vdata=%h want 0000 0",
                  {dmem_req, stall, wb_valid, err}, wb_vdata);
      end
      rst_n = 1'b1;
      dmem_ack = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick;
         dmem_ack = 1'b0;
         #1;
         checks++;
         if ({wb_valid, dmem_req, stall} !== 3'b000) begin
            errors++;
            $display("FAIL rst_stray%0d: got %b want 000", k,
                     {wb_valid, dmem_req, stall});
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset;
      test_alu;
      test_scalar_load;
      test_store;
      test_back_to_back;
      test_timeout;
      test_vector;
      test_reset_mid;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
